// File: rtl/pipeline_hazard_ctrl5_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// register-file constants and the load-detect rule.
package pipeline_hazard_ctrl5_pkg;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_IWAIT,
        HZ_IKILL,
        HZ_IREDIR
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    function automatic logic is_load(input logic [2:0] dm_rd_ctrl);
        return dm_rd_ctrl != 3'd0;
    endfunction

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use hazard compare: a load in IDR or EXB whose destination is read
// by the instruction entering IDR.
module hazard_lu_detect
    import pipeline_hazard_ctrl5_pkg::*;
(
    input  logic [4:0] rs1_IF,
    input  logic [4:0] rs2_IF,
    input  logic [4:0] rd_IDR,
    input  logic [4:0] rd_EXB,
    input  logic [2:0] dm_rd_ctrl_IDR,
    input  logic [2:0] dm_rd_ctrl_EXB,
    output logic       lu
);

    logic hit_idr;
    logic hit_exb;

    // x0 is never a real producer, so a load targeting it cannot create a hazard.
    always_comb begin
        hit_idr = is_load(dm_rd_ctrl_IDR) && (rd_IDR != REG_X0) &&
                  ((rd_IDR == rs1_IF) || (rd_IDR == rs2_IF));
        hit_exb = is_load(dm_rd_ctrl_EXB) && (rd_EXB != REG_X0) &&
                  ((rd_EXB == rs1_IF) || (rd_EXB == rs2_IF));
        lu      = hit_idr || hit_exb;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl5.sv
// Central stall/flush/redirect controller for the 5-stage pipeline, with a
// fetch-wait FSM that turns EXB branch decisions into one clean PC redirect.
module pipeline_hazard_ctrl5
    import pipeline_hazard_ctrl5_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_IF,
    input  logic [4:0]       rs2_IF,
    input  logic [4:0]       rd_IDR,
    input  logic [4:0]       rd_EXB,
    input  logic [2:0]       dm_rd_ctrl_IDR,
    input  logic [2:0]       dm_rd_ctrl_EXB,
    input  logic             branch_taken_EXB,
    input  logic [XLEN-1:0]  branch_target_EXB,
    input  logic             imem_req,
    input  logic             imem_ready,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             stall_IF,
    output logic             stall_IDR,
    output logic             stall_EXB,
    output logic             stall_EXA,
    output logic             stall_MEM,
    output logic             flush_IDR,
    output logic             flush_EXB,
    output logic             flush_WB,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] stall_cycles
);

    hz_state_t        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             br_done_q, br_done_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic lu;
    logic dw;
    logic br_ok;
    logic br_accept;
    logic fetch_stall;
    logic fetch_flush;
    logic redir_c;

    hazard_lu_detect u_lu_detect (
        .rs1_IF         (rs1_IF),
        .rs2_IF         (rs2_IF),
        .rd_IDR         (rd_IDR),
        .rd_EXB         (rd_EXB),
        .dm_rd_ctrl_IDR (dm_rd_ctrl_IDR),
        .dm_rd_ctrl_EXB (dm_rd_ctrl_EXB),
        .lu             (lu)
    );

    // br_done_q blocks a branch that stays asserted after its redirect was taken.
    always_comb begin
        dw    = dmem_req_MEM && !dmem_ready;
        br_ok = branch_taken_EXB && !lu && !dw && !br_done_q;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        br_accept   = 1'b0;
        fetch_stall = 1'b0;
        fetch_flush = 1'b0;
        redir_c     = 1'b0;
        case (state_q)
            HZ_RUN: begin
                if (br_ok) begin
                    br_accept   = 1'b1;
                    fetch_flush = 1'b1;
                    if (imem_req && !imem_ready) begin
                        pc_d    = branch_target_EXB;
                        state_d = HZ_IKILL;
                    end else begin
                        redir_c = 1'b1;
                    end
                end else if (imem_req && !imem_ready) begin
                    state_d = HZ_IWAIT;
                end
            end
            HZ_IWAIT: begin
                fetch_stall = 1'b1;
                fetch_flush = 1'b1;
                if (br_ok) begin
                    br_accept = 1'b1;
                    pc_d      = branch_target_EXB;
                    // A word returning with the branch is wrong-path: skip IKILL.
                    state_d   = imem_ready ? HZ_IREDIR : HZ_IKILL;
                end else if (imem_ready) begin
                    state_d = HZ_RUN;
                end
            end
            HZ_IKILL: begin
                fetch_stall = 1'b1;
                fetch_flush = 1'b1;
                if (imem_ready) begin
                    state_d = HZ_IREDIR;
                end
            end
            HZ_IREDIR: begin
                redir_c     = 1'b1;
                fetch_flush = 1'b1;
                if (!dw) begin
                    state_d = HZ_RUN;
                end
            end
            default: state_d = HZ_RUN;
        endcase
        br_done_d      = branch_taken_EXB && (br_done_q || br_accept);
        stall_cycles_d = stall_cycles_q + CNT_W'(stall_IF);
    end

    // Outputs are forced low while reset is asserted; a stalled IDR never
    // takes a flush from the fetch side.
    always_comb begin
        stall_IF       = reset && (fetch_stall || lu || dw);
        stall_IDR      = reset && (lu || dw);
        stall_EXB      = reset && dw;
        stall_EXA      = reset && dw;
        stall_MEM      = reset && dw;
        flush_IDR      = reset && fetch_flush && !lu && !dw;
        flush_EXB      = reset && lu && !dw;
        flush_WB       = reset && dw;
        redirect_valid = reset && redir_c;
        redirect_pc    = (state_q == HZ_RUN) ? branch_target_EXB : pc_q;
        stall_cycles   = stall_cycles_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= HZ_RUN;
            pc_q           <= '0;
            br_done_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            br_done_q      <= br_done_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl5.sv
// Directed bench for pipeline_hazard_ctrl5: table of RUN-state vectors plus
// hand-written multi-cycle FSM sequences.
module tb_pipeline_hazard_ctrl5;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_IF, rs2_IF, rd_IDR, rd_EXB;
    logic [2:0]  dm_rd_ctrl_IDR, dm_rd_ctrl_EXB;
    logic        branch_taken_EXB;
    logic [63:0] branch_target_EXB;
    logic        imem_req, imem_ready, dmem_req_MEM, dmem_ready;
    logic        stall_IF, stall_IDR, stall_EXB, stall_EXA, stall_MEM;
    logic        flush_IDR, flush_EXB, flush_WB, redirect_valid;
    logic [63:0] redirect_pc;
    logic [31:0] stall_cycles;

    logic [8:0]  outs;
    int          n_run  = 0;
    int          n_fail = 0;
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl5 #(.XLEN(64), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .rs1_IF(rs1_IF), .rs2_IF(rs2_IF), .rd_IDR(rd_IDR), .rd_EXB(rd_EXB),
        .dm_rd_ctrl_IDR(dm_rd_ctrl_IDR), .dm_rd_ctrl_EXB(dm_rd_ctrl_EXB),
        .branch_taken_EXB(branch_taken_EXB), .branch_target_EXB(branch_target_EXB),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
        .stall_IF(stall_IF), .stall_IDR(stall_IDR), .stall_EXB(stall_EXB),
        .stall_EXA(stall_EXA), .stall_MEM(stall_MEM),
        .flush_IDR(flush_IDR), .flush_EXB(flush_EXB), .flush_WB(flush_WB),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_cycles(stall_cycles)
    );

    // {stall IF,IDR,EXB,EXA,MEM, flush IDR,EXB,WB, redirect_valid}
    assign outs = {stall_IF, stall_IDR, stall_EXB, stall_EXA, stall_MEM,
                   flush_IDR, flush_EXB, flush_WB, redirect_valid};

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd_i, rd_e;
        logic [2:0]  ld_i, ld_e;
        logic        br;
        logic [63:0] tgt;
        logic        dreq, drdy;
        logic [8:0]  exp;
    } vec_t;

    vec_t vecs[12];

    task automatic set_idle();
        rs1_IF = 0; rs2_IF = 0; rd_IDR = 0; rd_EXB = 0;
        dm_rd_ctrl_IDR = 0; dm_rd_ctrl_EXB = 0;
        branch_taken_EXB = 0; branch_target_EXB = 0;
        imem_req = 0; imem_ready = 0; dmem_req_MEM = 0; dmem_ready = 0;
    endtask

    task automatic chk_cnt(input string nm);
        n_run++;
        if (stall_cycles !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s: stall_cycles=%0d expected %0d", nm, stall_cycles, exp_cnt);
        end
    endtask

    // One clock cycle: inputs already driven, compare on the falling edge.
    task automatic cyc(input string nm, input logic [8:0] e, input logic [63:0] epc);
        @(negedge clk);
        n_run++;
        if (outs !== e) begin
            n_fail++;
            $display("FAIL %s: outputs=%b expected %b", nm, outs, e);
        end
        if (e[0]) begin
            n_run++;
            if (redirect_pc !== epc) begin
                n_fail++;
                $display("FAIL %s_pc: redirect_pc=%h expected %h", nm, redirect_pc, epc);
            end
        end
        if (e[8]) exp_cnt++;
        @(posedge clk); #1;
    endtask

    initial begin
        //                rs1   rs2   rd_i  rd_e  ld_i ld_e br  tgt        dreq drdy  expected
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 64'h0,  1'b0, 1'b0, 9'b00000_000_0};
        vecs[1]  = '{5'd5, 5'd0, 5'd5, 5'd0, 3'd1, 3'd0, 1'b0, 64'h0,  1'b0, 1'b0, 9'b11000_010_0};
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 3'd1, 3'd0, 1'b0, 64'h0,  1'b0, 1'b0, 9'b00000_000_0};
        vecs[3]  = '{5'd3, 5'd7, 5'd0, 5'd7, 3'd0, 3'd2, 1'b0, 64'h0,  1'b0, 1'b0, 9'b11000_010_0};
        vecs[4]  = '{5'd5, 5'd0, 5'd5, 5'd0, 3'd0, 3'd0, 1'b0, 64'h0,  1'b0, 1'b0, 9'b00000_000_0};
        vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 64'h0,  1'b1, 1'b0, 9'b11111_001_0};
        vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 64'h0,  1'b1, 1'b1, 9'b00000_000_0};
        vecs[7]  = '{5'd5, 5'd0, 5'd5, 5'd0, 3'd1, 3'd0, 1'b0, 64'h0,  1'b1, 1'b0, 9'b11111_001_0};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 3'd0, 1'b1, 64'h80, 1'b0, 1'b0, 9'b00000_100_1};
        vecs[9]  = '{5'd0, 5'd9, 5'd9, 5'd0, 3'd4, 3'd0, 1'b1, 64'h84, 1'b0, 1'b0, 9'b11000_010_0};
        vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 3'd0, 1'b1, 64'h88, 1'b1, 1'b0, 9'b11111_001_0};
        vecs[11] = '{5'd6, 5'd0, 5'd6, 5'd6, 3'd0, 3'd0, 1'b1, 64'h90, 1'b0, 1'b0, 9'b00000_100_1};

        // Reset: outputs forced low even with a data wait and a branch pending.
        reset = 1'b0;
        set_idle();
        dmem_req_MEM = 1; branch_taken_EXB = 1; rs1_IF = 5; rd_IDR = 5; dm_rd_ctrl_IDR = 1;
        #2;
        n_run++;
        if (outs !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outs: outputs=%b expected %b", outs, 9'b0);
        end
        chk_cnt("reset_cnt");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        set_idle();

        // RUN-state vector table, each followed by an idle cycle.
        for (int i = 0; i < 12; i++) begin
            rs1_IF = vecs[i].rs1; rs2_IF = vecs[i].rs2;
            rd_IDR = vecs[i].rd_i; rd_EXB = vecs[i].rd_e;
            dm_rd_ctrl_IDR = vecs[i].ld_i; dm_rd_ctrl_EXB = vecs[i].ld_e;
            branch_taken_EXB = vecs[i].br; branch_target_EXB = vecs[i].tgt;
            dmem_req_MEM = vecs[i].dreq; dmem_ready = vecs[i].drdy;
            cyc($sformatf("vec%0d", i), vecs[i].exp, vecs[i].tgt);
            set_idle();
            cyc($sformatf("vec%0d_idle", i), 9'b0, 64'h0);
        end
        chk_cnt("cnt_vectors");

        // Load-use over two cycles: load in IDR, then the same load in EXB.
        rs1_IF = 5; rd_IDR = 5; dm_rd_ctrl_IDR = 1;
        cyc("lu_idr", 9'b11000_010_0, 64'h0);
        rd_IDR = 0; dm_rd_ctrl_IDR = 0; rd_EXB = 5; dm_rd_ctrl_EXB = 1;
        cyc("lu_exb", 9'b11000_010_0, 64'h0);
        set_idle(); rs1_IF = 5;
        cyc("lu_clear", 9'b0, 64'h0);

        // Data wait for three cycles.
        set_idle(); dmem_req_MEM = 1;
        for (int i = 0; i < 3; i++) cyc($sformatf("dw%0d", i), 9'b11111_001_0, 64'h0);
        dmem_ready = 1;
        cyc("dw_done", 9'b0, 64'h0);
        chk_cnt("cnt_dw");

        // IWAIT then branch to 0x100; fetch returns two cycles later.
        set_idle(); imem_req = 1;
        cyc("iw_enter", 9'b0, 64'h0);
        branch_taken_EXB = 1; branch_target_EXB = 64'h100;
        cyc("iw_branch", 9'b10000_100_0, 64'h0);
        branch_taken_EXB = 0; branch_target_EXB = 64'hdead;
        cyc("ikill_wait", 9'b10000_100_0, 64'h0);
        imem_ready = 1;
        cyc("ikill_ready", 9'b10000_100_0, 64'h0);
        set_idle(); branch_target_EXB = 64'hbeef;
        cyc("iredir", 9'b00000_100_1, 64'h100);
        cyc("iredir_after", 9'b0, 64'h0);

        // imem_ready and branch in the same IWAIT cycle.
        set_idle(); imem_req = 1;
        cyc("iw2_enter", 9'b0, 64'h0);
        imem_ready = 1; branch_taken_EXB = 1; branch_target_EXB = 64'h200;
        cyc("iw2_both", 9'b10000_100_0, 64'h0);
        set_idle();
        cyc("iw2_redir", 9'b00000_100_1, 64'h200);
        cyc("iw2_after", 9'b0, 64'h0);

        // Data wait while in IREDIR holds the redirect.
        set_idle(); imem_req = 1; branch_taken_EXB = 1; branch_target_EXB = 64'h300;
        cyc("run_br_wait", 9'b00000_100_0, 64'h0);
        branch_taken_EXB = 0; imem_ready = 1;
        cyc("kill_ready", 9'b10000_100_0, 64'h0);
        set_idle(); dmem_req_MEM = 1;
        cyc("redir_dw0", 9'b11111_001_1, 64'h300);
        cyc("redir_dw1", 9'b11111_001_1, 64'h300);
        dmem_ready = 1;
        cyc("redir_release", 9'b00000_100_1, 64'h300);
        set_idle();
        cyc("redir_done", 9'b0, 64'h0);

        // Branch blocked by load-use, then held high: exactly one redirect.
        set_idle(); branch_taken_EXB = 1; branch_target_EXB = 64'h400;
        rs1_IF = 5; rd_IDR = 5; dm_rd_ctrl_IDR = 1;
        cyc("br_lu", 9'b11000_010_0, 64'h0);
        dm_rd_ctrl_IDR = 0;
        cyc("br_after_lu", 9'b00000_100_1, 64'h400);
        cyc("br_held1", 9'b0, 64'h0);
        cyc("br_held2", 9'b0, 64'h0);
        set_idle();
        cyc("br_low", 9'b0, 64'h0);
        chk_cnt("cnt_fsm");

        // Reset asserted in IKILL drops the pending redirect.
        set_idle(); imem_req = 1; branch_taken_EXB = 1; branch_target_EXB = 64'h500;
        cyc("rst_br_wait", 9'b00000_100_0, 64'h0);
        branch_taken_EXB = 0;
        reset = 1'b0;
        #1;
        n_run++;
        if (outs !== 9'b0) begin
            n_fail++;
            $display("FAIL rst_ikill_outs: outputs=%b expected %b", outs, 9'b0);
        end
        exp_cnt = 0;
        chk_cnt("rst_ikill_cnt");
        @(posedge clk); #1;
        reset = 1'b1;
        imem_req = 1; imem_ready = 1;
        cyc("rst_post_ready", 9'b0, 64'h0);
        set_idle();
        cyc("rst_post_idle", 9'b0, 64'h0);
        cyc("rst_post_idle2", 9'b0, 64'h0);
        chk_cnt("cnt_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl5.md
# pipeline_hazard_ctrl5

Central stall/flush/redirect controller for the 5-stage pipeline (IF, IDR, EXB, EXA, MEM, WB). It detects load-use hazards, sequences instruction- and data-memory wait states, and turns the EXB branch decision into a single clean PC redirect. Every pipeline stage register takes its `stall_*` and `flush_*` inputs from this block. It also keeps a stall-cycle performance counter.

## Interface
- `XLEN`, 64: PC/address width.
- `CNT_W`, 32: stall counter width.

- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-low.
- `rs1_IF`, `rs2_IF` in 5 each: source registers of the instruction entering IDR.
- `rd_IDR`, `rd_EXB` in 5 each: destination registers held in the IDR and EXB stage registers.
- `dm_rd_ctrl_IDR`, `dm_rd_ctrl_EXB` in 3 each: nonzero marks a load.
- `branch_taken_EXB` in 1: combinational branch/jump decision.
- `branch_target_EXB` in XLEN: target for `branch_taken_EXB`.
- `imem_req` in 1: IF has a fetch outstanding.
- `imem_ready` in 1: fetch data valid this cycle.
- `dmem_req_MEM` in 1: MEM stage has a load/store.
- `dmem_ready` in 1: data access completes this cycle.
- `stall_IF`, `stall_IDR`, `stall_EXB`, `stall_EXA`, `stall_MEM` out 1 each: hold the stage register.
- `flush_IDR`, `flush_EXB`, `flush_WB` out 1 each: load a bubble into the stage register.
- `redirect_valid` out 1: IF loads `redirect_pc` this cycle.
- `redirect_pc` out XLEN: redirect target.
- `stall_cycles` out CNT_W: count of cycles with `stall_IF`=1.

## Operation
- **Load-use hazard (`lu`).**
  - `lu` = 1 when `dm_rd_ctrl_IDR`≠0, `rd_IDR`≠0 and `rd_IDR` matches `rs1_IF` or `rs2_IF`.
  - `lu` = 1 under the same rule applied to `dm_rd_ctrl_EXB` and `rd_EXB`.
  - Response: `stall_IF`=`stall_IDR`=1, `flush_EXB`=1. This gives a 2-bubble worst case.
- **Data wait (`dw`).**
  - `dw` = `dmem_req_MEM` & ~`dmem_ready`.
  - Response: all five stalls = 1 and `flush_WB`=1.
  - `dw` overrides `lu` bubbles: `flush_EXB`=0 while `dw`=1.
- **Redirect qualification.** `br_ok` = `branch_taken_EXB` & ~`lu` & ~`dw`. A branch whose operands depend on a load never redirects early.
- **FSM states:** RUN, IWAIT, IKILL, IREDIR.
- **RUN**
  - `br_ok` with `imem_req` & ~`imem_ready`: latch the target into `redirect_pc`, go IKILL, `flush_IDR`=1.
  - `br_ok` otherwise: `redirect_valid`=1, `redirect_pc`=`branch_target_EXB` (combinational), `flush_IDR`=1.
  - `imem_req` & ~`imem_ready` & ~`br_ok`: go IWAIT.
- **IWAIT**
  - `stall_IF`=1. `flush_IDR`=1 unless `lu` or `dw`.
  - `br_ok`: latch the target, go IKILL.
  - `imem_ready`: go RUN.
- **IKILL**
  - `stall_IF`=1, `flush_IDR`=1.
  - On `imem_ready`, the returned word is discarded; go IREDIR.
- **IREDIR**
  - `redirect_valid`=1 with the latched pc, `flush_IDR`=1, for one cycle; go RUN.
  - If `dw`=1 in IREDIR, the state and `redirect_valid` hold until `dw` clears.
- **Precedence.** `dw` > `lu` > branch > fetch wait. A stalled stage never receives a flush from a lower-priority cause.
- **Stall counter.** `stall_cycles` increments by 1 per cycle with `stall_IF`=1 and wraps modulo 2^CNT_W.

## Timing
- Stalls, flushes and `redirect_valid` are combinational from inputs and state, valid in the same cycle.
- State, the latched pc and the counter update on `posedge clk`.
- Reset (`reset`=0, asynchronous):
  - state RUN, latched pc 0, `stall_cycles` 0.
  - All stall, flush and redirect outputs forced to 0 while `reset` is low.
- Reset mid-IKILL drops the pending redirect; it is not replayed.
- Redirect latency:
  - 0 cycles in RUN.
  - In IWAIT, one cycle after the cycle in which `imem_ready` is high in IKILL.
- `branch_taken_EXB` held high over several stalled cycles produces exactly one redirect.
- `imem_ready` and `br_ok` in the same IWAIT cycle: branch wins, the returned word is flushed, and the FSM goes IREDIR directly.

## Structure
- The shared package holds:
  - the FSM state enum (`hz_state_t`);
  - the load detect rule (`dm_rd_ctrl`≠0);
  - the x0 index constant.
- One natural sub-module, `hazard_lu_detect`: combinational load-use compare that outputs `lu`.

## Test plan
- Load to x5 in IDR, consumer `rs1_IF`=5 → `stall_IF`/`stall_IDR`=1 and `flush_EXB`=1 for 2 cycles. With rd=0, no stall.
- `dmem_req_MEM`=1, `dmem_ready` low for 3 cycles → all stalls=1 and `flush_WB`=1 for exactly 3 cycles; `stall_cycles` +3.
- Branch taken in RUN, target 0x80 → `redirect_valid`=1 and `flush_IDR`=1 in the same cycle, once only.
- IWAIT plus branch to 0x100, `imem_ready` 2 cycles later → the returned word is flushed, then a one-cycle redirect to 0x100.
- `branch_taken_EXB` and `lu` together → no redirect until `lu` clears. `dw` during IREDIR → redirect held until `dmem_ready`.
- Assert `reset`=0 in IKILL → outputs 0 immediately, state RUN, no redirect after release.
